// File: rtl/vehicle_sensor_conditioner.sv
// vehicle_sensor_conditioner: debounced, latched road-B vehicle request with arrival count and stuck-loop fail-safe
module vehicle_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STUCK_CYCLES    = 200,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               loop_raw,
  input  logic               serve_b,
  input  logic               count_clr,
  output logic               sensorB,
  output logic [COUNT_W-1:0] vehicle_count,
  output logic               fault
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_ONE    = DW'(1);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES);
  typedef enum logic [1:0] {LOW, QUAL_H, HIGH, QUAL_L} db_state_t;
  db_state_t state, state_n;
  logic [DW-1:0] db_cnt, db_cnt_n;
  logic [SW-1:0] stuck_cnt;
  logic s1, s2, filtered, arrival, req;
  assign filtered = (state == HIGH) || (state == QUAL_L);
  assign fault    = stuck_cnt == STUCK_MAX;
  assign sensorB  = req | (fault & ~serve_b);
  // two-flop synchroniser for the asynchronous loop input
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s1, s2} <= 2'b00;
    else {s1, s2} <= {loop_raw, s1};
  // debounce state and qualification counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state  <= LOW;
      db_cnt <= '0;
    end else begin
      state  <= state_n;
      db_cnt <= db_cnt_n;
    end
  // debounce transitions; with a one-sample window the qualify states are skipped
  always_comb begin
    state_n  = state;
    db_cnt_n = db_cnt;
    arrival  = 1'b0;
    case (state)
      LOW: if (s2) begin
        state_n  = (DEBOUNCE_CYCLES == 1) ? HIGH : QUAL_H;
        db_cnt_n = (DEBOUNCE_CYCLES == 1) ? '0 : DB_ONE;
        arrival  = DEBOUNCE_CYCLES == 1;
      end
      QUAL_H: begin
        state_n  = !s2 ? LOW : (db_cnt == DB_LAST) ? HIGH : QUAL_H;
        db_cnt_n = (!s2 || db_cnt == DB_LAST) ? '0 : db_cnt + 1'b1;
        arrival  = s2 && db_cnt == DB_LAST;
      end
      HIGH: if (!s2) begin
        state_n  = (DEBOUNCE_CYCLES == 1) ? LOW : QUAL_L;
        db_cnt_n = (DEBOUNCE_CYCLES == 1) ? '0 : DB_ONE;
      end
      default: begin
        state_n  = s2 ? HIGH : (db_cnt == DB_LAST) ? LOW : QUAL_L;
        db_cnt_n = (s2 || db_cnt == DB_LAST) ? '0 : db_cnt + 1'b1;
      end
    endcase
  end
  // request latch, saturating arrival counter and stuck-high timer
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      req           <= 1'b0;
      vehicle_count <= '0;
      stuck_cnt     <= '0;
    end else begin
      req           <= serve_b ? 1'b0 : (arrival | req);
      vehicle_count <= count_clr ? COUNT_W'(arrival) :
                       (arrival && vehicle_count != '1) ? vehicle_count + 1'b1 : vehicle_count;
      stuck_cnt     <= !filtered ? '0 : (stuck_cnt == STUCK_MAX) ? stuck_cnt : stuck_cnt + 1'b1;
    end
endmodule

// File: tb/tb_vehicle_sensor_conditioner.sv
// tb_vehicle_sensor_conditioner: scoreboard bench for the road-B loop conditioner
module tb_vehicle_sensor_conditioner;
  localparam int STUCK = 200;
  logic clk = 1'b0, reset = 1'b0, loop_raw = 1'b0, serve_b = 1'b0, count_clr = 1'b0;
  logic sensorB, fault;
  logic [1:0] vehicle_count;
  int checks = 0, errors = 0, cyc = 0, k = 0, r = 0;
  typedef struct {
    string      tag;
    int         at;
    logic       sb;
    logic [1:0] cnt;
    logic       flt;
  } exp_t;
  exp_t sb_q[$];
  exp_t cur;
  int ex_cnt[5] = '{1, 2, 3, 3, 3};

  vehicle_sensor_conditioner #(.DEBOUNCE_CYCLES(4), .STUCK_CYCLES(STUCK), .COUNT_W(2)) dut (
    .clk(clk), .reset(reset), .loop_raw(loop_raw), .serve_b(serve_b), .count_clr(count_clr),
    .sensorB(sensorB), .vehicle_count(vehicle_count), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp_v, cyc);
    end
  endtask

  task automatic push_exp(input string tag, input int dly, input logic sb, input logic [1:0] cnt, input logic flt);
    sb_q.push_back('{tag, cyc + dly, sb, cnt, flt});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input string tag, input int n, input logic sb, input logic [1:0] cnt, input logic flt);
    repeat (n) begin
      push_exp(tag, 0, sb, cnt, flt);
      tick(1);
    end
  endtask

  task automatic arrival(input string tag, input logic srv, input logic clr, input logic sb, input logic [1:0] cnt);
    loop_raw = 1'b1;
    push_exp(tag, 6, sb, cnt, 1'b0);
    tick(5);
    serve_b   = srv;
    count_clr = clr;
    tick(1);
    serve_b   = 1'b0;
    count_clr = 1'b0;
    loop_raw  = 1'b0;
    tick(8);
  endtask

  always @(negedge clk)
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      cur = sb_q.pop_front();
      check({cur.tag, "_sensorB"}, int'(sensorB), int'(cur.sb));
      check({cur.tag, "_count"}, int'(vehicle_count), int'(cur.cnt));
      check({cur.tag, "_fault"}, int'(fault), int'(cur.flt));
    end

  initial begin
    tick(2);
    hold("rst", 1, 1'b0, 2'd0, 1'b0);
    reset = 1'b1;
    hold("rst_rel", 2, 1'b0, 2'd0, 1'b0);
    loop_raw = 1'b1;
    push_exp("t1_pre", 5, 1'b0, 2'd0, 1'b0);
    push_exp("t1_arr", 6, 1'b1, 2'd1, 1'b0);
    push_exp("t1_hold", 20, 1'b1, 2'd1, 1'b0);
    tick(21);
    loop_raw = 1'b0;
    tick(8);
    serve_b = 1'b1;
    push_exp("t3_serve", 1, 1'b0, 2'd1, 1'b0);
    tick(1);
    serve_b   = 1'b0;
    count_clr = 1'b1;
    push_exp("clr", 1, 1'b0, 2'd0, 1'b0);
    tick(1);
    count_clr = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      loop_raw = 1'b1;
      hold("t2_hi", p, 1'b0, 2'd0, 1'b0);
      loop_raw = 1'b0;
      hold("t2_lo", 5, 1'b0, 2'd0, 1'b0);
    end
    hold("t2_tail", 8, 1'b0, 2'd0, 1'b0);
    arrival("t3_coinc", 1'b1, 1'b0, 1'b0, 2'd1);
    hold("t3_after", 2, 1'b0, 2'd1, 1'b0);
    count_clr = 1'b1;
    push_exp("t4_clr", 1, 1'b0, 2'd0, 1'b0);
    tick(1);
    count_clr = 1'b0;
    for (int i = 0; i < 5; i++) arrival($sformatf("t4_arr%0d", i), 1'b0, 1'b0, 1'b1, 2'(ex_cnt[i]));
    arrival("t4_clr_arr", 1'b0, 1'b1, 1'b1, 2'd1);
    serve_b = 1'b1;
    tick(1);
    serve_b  = 1'b0;
    k        = cyc;
    loop_raw = 1'b1;
    for (int j = 0; j < 250; j++) begin
      serve_b = j[0];
      if (j >= 10) push_exp("t5_stuck", 0, (cyc >= k + STUCK + 6) && !serve_b, 2'd2, cyc >= k + STUCK + 6);
      tick(1);
    end
    r        = cyc;
    loop_raw = 1'b0;
    serve_b  = 1'b0;
    push_exp("t5_flt_hold", 6, 1'b1, 2'd2, 1'b1);
    push_exp("t5_flt_clr", 7, 1'b0, 2'd2, 1'b0);
    tick(8);
    arrival("t6_arr", 1'b0, 1'b0, 1'b1, 2'd3);
    loop_raw = 1'b1;
    tick(3);
    check("t6_pre_sensorB", int'(sensorB), 1);
    #2 reset = 1'b0;
    #1;
    check("t6_async_sensorB", int'(sensorB), 0);
    check("t6_async_count", int'(vehicle_count), 0);
    check("t6_async_fault", int'(fault), 0);
    tick(2);
    reset = 1'b1;
    push_exp("t6_pre", 5, 1'b0, 2'd0, 1'b0);
    push_exp("t6_new", 6, 1'b1, 2'd1, 1'b0);
    tick(8);
    tick(2);
    check("drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
